// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller front end: FSM encoding,
// default sizing and the mask reset value.
package irq_pkg;

    localparam int N_IRQ_DEF = 8;
    localparam int ID_W_DEF  = 3;

    // Wide enough for any practical N_IRQ; users truncate to their width.
    localparam logic [63:0] MASK_RST = '1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_REQ_M     = 3'd1,
        ST_REQ_N     = 3'd2,
        ST_SERVICE_M = 3'd3,
        ST_SERVICE_N = 3'd4
    } irq_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// Request/acknowledge and mask bus between the interrupt front end and the rest
// of the core; the controller sits on the slave side.
interface irq_controller_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) ();

    logic [N_IRQ-1:0] irq_in;
    logic             nmi_in;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic             respond;
    logic             eoi;
    logic             interrupt;
    logic             non_maskable_int;
    logic             busy;
    logic [ID_W-1:0]  irq_id;
    logic [N_IRQ-1:0] pending;
    logic [N_IRQ-1:0] mask;

    modport master (
        output irq_in, nmi_in, mask_we, mask_wdata, respond, eoi,
        input  interrupt, non_maskable_int, busy, irq_id, pending, mask
    );

    modport slave (
        input  irq_in, nmi_in, mask_we, mask_wdata, respond, eoi,
        output interrupt, non_maskable_int, busy, irq_id, pending, mask
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for asynchronous request lines followed by a
// rising-edge detector producing a one-cycle pulse per rising edge.
module irq_sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;
    logic [W-1:0] r_prev;

    // NOTE: non-blocking assignments make the three stages shift together;
    // blocking ones would collapse the chain into a single flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/irq_controller.sv
// Interrupt front end: holds synchronized request edges as pending, applies the
// software mask and hands one source at a time to Interrupt_state.
module irq_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    irq_controller_if.slave  bus
);

    logic [N_IRQ-1:0] w_irq_rise;
    logic             w_nmi_rise;

    irq_sync_edge #(.W(N_IRQ)) u_irq_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (bus.irq_in),
        .o_rise (w_irq_rise)
    );

    irq_sync_edge #(.W(1)) u_nmi_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_d    (bus.nmi_in),
        .o_rise (w_nmi_rise)
    );

    irq_state_e       r_state;
    irq_state_e       w_state_nxt;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic             r_nmi_pend;
    logic [ID_W-1:0]  r_irq_id;

    logic [N_IRQ-1:0] w_eligible;
    logic [ID_W-1:0]  w_pick_id;
    logic [N_IRQ-1:0] w_clr_vec;
    logic             w_clr_m;
    logic             w_nmi_clr;
    logic             w_load_id;

    assign w_eligible = r_pending & ~r_mask;

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        w_pick_id = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) w_pick_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // NOTE: every signal gets its default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_load_id   = 1'b0;
        w_clr_m     = 1'b0;
        w_nmi_clr   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_nmi_pend) begin
                    w_state_nxt = ST_REQ_N;
                end else if (|w_eligible) begin
                    w_state_nxt = ST_REQ_M;
                    w_load_id   = 1'b1;
                end
            end
            ST_REQ_M: begin
                // An acknowledge already on the wire completes the grant before NMI preempts.
                if (bus.respond) begin
                    w_clr_m     = 1'b1;
                    w_state_nxt = ST_SERVICE_M;
                end else if (r_nmi_pend) begin
                    w_state_nxt = ST_REQ_N;
                end
            end
            ST_REQ_N: begin
                if (bus.respond) begin
                    w_nmi_clr   = 1'b1;
                    w_state_nxt = ST_SERVICE_N;
                end
            end
            ST_SERVICE_M, ST_SERVICE_N: begin
                if (bus.eoi) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_clr_vec = '0;
        if (w_clr_m) w_clr_vec[r_irq_id] = 1'b1;
    end

    // New edges are ORed in after the clear so a same-cycle set survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending  <= '0;
            r_nmi_pend <= 1'b0;
            r_mask     <= N_IRQ'(MASK_RST);
            r_irq_id   <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_clr_vec) | w_irq_rise;
            r_nmi_pend <= (r_nmi_pend & ~w_nmi_clr) | w_nmi_rise;
            if (bus.mask_we) r_mask <= bus.mask_wdata;
            if (w_load_id)   r_irq_id <= w_pick_id;
        end
    end

    assign bus.interrupt        = (r_state == ST_REQ_M);
    assign bus.non_maskable_int = (r_state == ST_REQ_N);
    assign bus.busy             = (r_state == ST_SERVICE_M) || (r_state == ST_SERVICE_N);
    assign bus.irq_id           = r_irq_id;
    assign bus.pending          = r_pending;
    assign bus.mask             = r_mask;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_irq_controller;

    logic clk;
    logic rst_n;

    irq_controller_if #(.N_IRQ(8), .ID_W(3)) bus ();

    irq_controller #(.N_IRQ(8), .ID_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_req/m_svc hold the source id (0..7 maskable, 8 = NMI, -1 none).
    logic [7:0] m_pend, m_mask;
    logic       m_nmi_p;
    int         m_req, m_svc;
    logic [2:0] m_id;
    logic [8:0] h0, h1, h2;   // input levels seen at the previous 1, 2, 3 edges

    task automatic model_reset();
        m_pend  = 8'h00;
        m_mask  = 8'hFF;
        m_nmi_p = 1'b0;
        m_req   = -1;
        m_svc   = -1;
        m_id    = 3'd0;
        h0 = '0; h1 = '0; h2 = '0;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [8:0] x, rise;
        logic [7:0] elig, clr;
        logic       nclr;
        x    = {bus.nmi_in, bus.irq_in};
        rise = h1 & ~h2;            // level seen two edges back, low three edges back
        h2 = h1; h1 = h0; h0 = x;
        elig = m_pend & ~m_mask;
        clr  = 8'h00;
        nclr = 1'b0;
        if (m_req < 0 && m_svc < 0) begin
            if (m_nmi_p) m_req = 8;
            else if (elig != 8'h00) begin
                m_req = lowest(elig);
                m_id  = 3'(m_req);
            end
        end else if (m_req >= 0 && m_req < 8) begin
            if (bus.respond) begin
                clr[m_req] = 1'b1;
                m_svc = m_req;
                m_req = -1;
            end else if (m_nmi_p) begin
                m_req = 8;
            end
        end else if (m_req == 8) begin
            if (bus.respond) begin
                nclr  = 1'b1;
                m_svc = 8;
                m_req = -1;
            end
        end else if (bus.eoi) begin
            m_svc = -1;
        end
        m_pend  = (m_pend & ~clr) | rise[7:0];
        m_nmi_p = (m_nmi_p & ~nclr) | rise[8];
        if (bus.mask_we) m_mask = bus.mask_wdata;
    endtask

    task automatic compare_model();
        logic e_int, e_busy_m;
        e_int    = (m_req >= 0 && m_req < 8);
        e_busy_m = (m_svc >= 0 && m_svc < 8);
        check("model_interrupt", bus.interrupt, e_int);
        check("model_nmi", bus.non_maskable_int, m_req == 8);
        check("model_busy", bus.busy, m_svc >= 0);
        check("model_pending", bus.pending, m_pend);
        check("model_mask", bus.mask, m_mask);
        if (e_int || e_busy_m) check("model_irq_id", bus.irq_id, m_id);
    endtask

    logic [7:0] g_irq;
    logic       g_nmi;

    // One clock: drive after the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic step(input logic mwe, input logic [7:0] mwd, input logic rsp, input logic e);
        bus.irq_in     = g_irq;
        bus.nmi_in     = g_nmi;
        bus.mask_we    = mwe;
        bus.mask_wdata = mwd;
        bus.respond    = rsp;
        bus.eoi        = e;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    // Bounded wait for interrupt (sel=0) or non_maskable_int (sel=1).
    task automatic wait_req(input int sel, input int budget, input string name);
        int n;
        n = 0;
        while (!(sel == 0 ? bus.interrupt : bus.non_maskable_int) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, (sel == 0 ? bus.interrupt : bus.non_maskable_int), 1'b1);
    endtask

    typedef struct {
        logic [7:0] irq;
        logic       mwe;
        logic [7:0] mwd;
        logic       rsp;
        logic       eoi;
        logic       e_int;
        logic       e_busy;
        logic [2:0] e_id;
        logic [7:0] e_pend;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[1] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[2] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00};
        tbl[3] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h20};
        tbl[4] = '{8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h20};
        tbl[5] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 8'h20};
        tbl[6] = '{8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00};
        tbl[7] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00};
        tbl[8] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 8'h00};
        tbl[9] = '{8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00};

        g_irq = 8'h00;
        g_nmi = 1'b0;
        bus.irq_in = '0; bus.nmi_in = 1'b0; bus.mask_we = 1'b0;
        bus.mask_wdata = '0; bus.respond = 1'b0; bus.eoi = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_interrupt", bus.interrupt, 1'b0);
        check("rst_nmi", bus.non_maskable_int, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_irq_id", bus.irq_id, 3'd0);
        check("rst_pending", bus.pending, 8'h00);
        check("rst_mask", bus.mask, 8'hFF);
        rst_n = 1'b1;

        // Basic request/grant/service on line 5
        for (int i = 0; i < 10; i++) begin
            g_irq = tbl[i].irq;
            step(tbl[i].mwe, tbl[i].mwd, tbl[i].rsp, tbl[i].eoi);
            check($sformatf("vec%0d_interrupt", i), bus.interrupt, tbl[i].e_int);
            check($sformatf("vec%0d_busy", i), bus.busy, tbl[i].e_busy);
            check($sformatf("vec%0d_pending", i), bus.pending, tbl[i].e_pend);
            if (tbl[i].e_int || tbl[i].e_busy)
                check($sformatf("vec%0d_irq_id", i), bus.irq_id, tbl[i].e_id);
        end

        // Simultaneous lines 2 and 6: lowest index first, then one idle cycle
        g_irq = 8'h44;
        wait_req(0, 8, "seq2_first_req");
        check("seq2_first_id", bus.irq_id, 3'd2);
        g_irq = 8'h00;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("seq2_busy", bus.busy, 1'b1);
        check("seq2_pend6", bus.pending, 8'h40);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("seq2_gap", bus.interrupt, 1'b0);
        tick(1);
        check("seq2_second_req", bus.interrupt, 1'b1);
        check("seq2_second_id", bus.irq_id, 3'd6);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Masked line stays pending, then becomes eligible after unmask
        step(1'b1, 8'h08, 1'b0, 1'b0);
        g_irq = 8'h08;
        tick(4);
        check("seq3_pend3", bus.pending[3], 1'b1);
        check("seq3_masked_quiet", bus.interrupt, 1'b0);
        step(1'b1, 8'h00, 1'b0, 1'b0);
        wait_req(0, 2, "seq3_unmask_req");
        check("seq3_id", bus.irq_id, 3'd3);
        g_irq = 8'h00;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // NMI preempts an unacknowledged maskable request
        g_irq = 8'h02;
        wait_req(0, 8, "seq4_req");
        check("seq4_id", bus.irq_id, 3'd1);
        g_nmi = 1'b1;
        wait_req(1, 6, "seq4_nmi_req");
        check("seq4_int_dropped", bus.interrupt, 1'b0);
        check("seq4_pend1_kept", bus.pending[1], 1'b1);
        g_nmi = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("seq4_nmi_busy", bus.busy, 1'b1);
        check("seq4_nmi_low", bus.non_maskable_int, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        wait_req(0, 3, "seq4_rereq");
        check("seq4_reid", bus.irq_id, 3'd1);

        // NMI edge during maskable service is held until eoi
        g_irq = 8'h00;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        g_nmi = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("seq5_nmi_held", bus.non_maskable_int, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("seq5_idle_after_eoi", bus.busy, 1'b0);
        tick(1);
        check("seq5_nmi_req", bus.non_maskable_int, 1'b1);
        g_nmi = 1'b0;
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset while a maskable request is outstanding
        g_irq = 8'h21;
        wait_req(0, 8, "seq6_req");
        check("seq6_pend", bus.pending, 8'h21);
        check("seq6_id", bus.irq_id, 3'd0);
        #2;
        rst_n = 1'b0;
        g_irq = 8'h00;
        bus.irq_in = 8'h00;
        #1;
        model_reset();
        check("seq6_rst_interrupt", bus.interrupt, 1'b0);
        check("seq6_rst_busy", bus.busy, 1'b0);
        check("seq6_rst_irq_id", bus.irq_id, 3'd0);
        check("seq6_rst_pending", bus.pending, 8'h00);
        check("seq6_rst_mask", bus.mask, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("seq6_no_req", bus.interrupt | bus.non_maskable_int, 1'b0);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic       mwe, rsp, e;
            logic [7:0] mwd;
            if ($urandom_range(0, 5) == 0) g_irq = g_irq ^ (8'h01 << $urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) g_nmi = ~g_nmi;
            mwe = ($urandom_range(0, 15) == 0);
            mwd = 8'($urandom);
            rsp = ($urandom_range(0, 3) == 0);
            e   = ($urandom_range(0, 4) == 0);
            step(mwe, mwd, rsp, e);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
